// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan chain controller.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    UNLOAD  = 2'd3
  } scan_state_t;

  // Counter width able to hold the value CHAIN_LEN.
  function automatic int unsigned cnt_width(input int unsigned chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Sequencer-side handshake between the test sequencer and the scan controller.
interface scan_chain_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 8
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] response;

  modport master (output start, pattern, input busy, done, response);
  modport slave  (input start, pattern, output busy, done, response);
endinterface

// File: rtl/sdff.sv
// Mux-D scan flip-flop cell: SE selects SI over the functional D input.
module sdff (
  input  logic CLK,
  input  logic D,
  input  logic SI,
  input  logic SE,
  output logic Q
);
  always_ff @(posedge CLK) begin
    Q <= SE ? SI : D;
  end
endmodule

// File: rtl/scan_chain_ctrl.sv
// Loads a parallel pattern into a scan chain, pulses one capture cycle,
// then unloads the captured response as a parallel word.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 8
) (
  input  logic             CLK,
  input  logic             R,
  scan_chain_ctrl_if.slave seq,
  input  logic             SO,
  output logic             SE,
  output logic             SI
);

  localparam int unsigned CW = cnt_width(CHAIN_LEN);
  localparam int unsigned SW = CHAIN_LEN - 1;

  scan_state_t state, state_nx;

  logic [CW-1:0]        cnt, cnt_d;
  logic [SW-1:0]        load, load_d;
  logic [SW-1:0]        unload, unload_d;
  logic [CHAIN_LEN-1:0] resp, resp_d;
  logic                 busy, busy_d;
  logic                 done, done_d;
  logic                 se_d, si_d;
  logic                 cnt_last;

  assign cnt_last     = (cnt == CW'(CHAIN_LEN - 1));
  assign seq.busy     = busy;
  assign seq.done     = done;
  assign seq.response = resp;

  // State register
  always_ff @(posedge CLK) begin
    if (R) state <= IDLE;
    else   state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (seq.start) state_nx = SHIFT;
      SHIFT:   if (cnt_last)  state_nx = CAPTURE;
      CAPTURE:                state_nx = UNLOAD;
      UNLOAD:  if (cnt_last)  state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Next values for every registered output and datapath register
  always_comb begin
    se_d     = 1'b0;
    si_d     = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    cnt_d    = cnt;
    load_d   = load;
    unload_d = unload;
    resp_d   = resp;
    case (state)
      IDLE: begin
        if (seq.start) begin
          // bit 0 goes straight to SI; only the remaining bits need holding
          load_d = seq.pattern[CHAIN_LEN-1:1];
          si_d   = seq.pattern[0];
          se_d   = 1'b1;
          busy_d = 1'b1;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        si_d   = load[0];
        load_d = load >> 1;
        se_d   = !cnt_last;
        cnt_d  = cnt_last ? '0 : CW'(cnt + 1'b1);
      end
      CAPTURE: begin
        se_d  = 1'b1;
        cnt_d = '0;
      end
      UNLOAD: begin
        // first sample out of SO belongs to flop 0, so it ends up in bit 0
        unload_d = SW'({SO, unload} >> 1);
        se_d     = !cnt_last;
        cnt_d    = cnt_last ? '0 : CW'(cnt + 1'b1);
        if (cnt_last) begin
          resp_d = {SO, unload};
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge CLK) begin
    if (R) begin
      SE     <= 1'b0;
      SI     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      load   <= '0;
      unload <= '0;
      resp   <= '0;
    end else begin
      SE     <= se_d;
      SI     <= si_d;
      busy   <= busy_d;
      done   <= done_d;
      cnt    <= cnt_d;
      load   <= load_d;
      unload <= unload_d;
      resp   <= resp_d;
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl driving real sdff chains of length 8 and 2.
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  logic r;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8-flop chain: flop 7 is the head fed by SI, flop 0 the tail driving SO
  scan_chain_ctrl_if #(.CHAIN_LEN(8)) s8 ();
  logic       se8, si8, so8;
  logic [7:0] d8, q8, dsel8;
  logic [8:0] sc8;
  bit         tr8;
  assign dsel8   = tr8 ? q8 : d8;
  assign sc8[8]  = si8;
  assign sc8[7:0] = q8;
  assign so8     = q8[0];

  scan_chain_ctrl #(.CHAIN_LEN(8)) dut8 (
    .CLK(clk), .R(r), .seq(s8), .SO(so8), .SE(se8), .SI(si8)
  );
  for (genvar i = 0; i < 8; i++) begin : g_c8
    sdff u_ff (.CLK(clk), .D(dsel8[i]), .SI(sc8[i+1]), .SE(se8), .Q(q8[i]));
  end

  // 2-flop chain for the minimum length
  scan_chain_ctrl_if #(.CHAIN_LEN(2)) s2 ();
  logic       se2, si2, so2;
  logic [1:0] d2, q2;
  logic [2:0] sc2;
  assign sc2[2]   = si2;
  assign sc2[1:0] = q2;
  assign so2      = q2[0];

  scan_chain_ctrl #(.CHAIN_LEN(2)) dut2 (
    .CLK(clk), .R(r), .seq(s2), .SO(so2), .SE(se2), .SI(si2)
  );
  for (genvar i = 0; i < 2; i++) begin : g_c2
    sdff u_ff (.CLK(clk), .D(d2[i]), .SI(sc2[i+1]), .SE(se2), .Q(q2[i]));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboards: expected responses queued at launch, popped when done pulses
  logic [7:0] sb8[$];
  logic [1:0] sb2[$];

  always @(negedge clk) begin
    if (s8.done === 1'b1) begin
      if (sb8.size() == 0) check("spurious_done8", 32'(s8.done), 32'd0);
      else                 check("resp8", 32'(s8.response), 32'(sb8.pop_front()));
    end
    if (s2.done === 1'b1) begin
      if (sb2.size() == 0) check("spurious_done2", 32'(s2.done), 32'd0);
      else                 check("resp2", 32'(s2.response), 32'(sb2.pop_front()));
    end
  end

  // One N=8 run; j counts edges after the accepting edge
  task automatic run8(input logic [7:0] pat, input logic [7:0] dv, input bit transp,
                      input logic [7:0] exp, input bit pre, input bit midpulse,
                      input bit chain, input logic [7:0] npat, input logic [7:0] ndv);
    int se_hi, si_bad, busy_bad, lat;
    lat = 0; si_bad = 0; busy_bad = 0;
    if (!pre) begin
      @(negedge clk);
      s8.start = 1'b1; s8.pattern = pat;
      sb8.push_back(exp);
    end
    d8 = dv; tr8 = transp;
    @(negedge clk);
    s8.start = 1'b0; s8.pattern = ~pat;
    check("busy8_rise", 32'(s8.busy), 32'd1);
    se_hi = (se8 === 1'b1) ? 1 : 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (s8.done === 1'b1) begin
        lat = j;
        break;
      end
      if (se8 === 1'b1) se_hi++;
      if (j == 8) begin
        check("se8_capture_low", 32'(se8), 32'd0);
        check("chain_load8", 32'(q8), 32'(pat));
      end
      if (j > 8 && j <= 16 && si8 !== 1'b0) si_bad++;
      if (s8.busy !== 1'b1) busy_bad++;
      if (midpulse) begin
        s8.start   = (j == 3);
        s8.pattern = 8'h00;
      end
      if (chain && j == 16) begin
        s8.start = 1'b1; s8.pattern = npat;
        d8 = ndv; tr8 = 1'b0;
        sb8.push_back(ndv);
      end
    end
    check("latency8", 32'(lat), 32'd17);
    check("se8_high_cycles", 32'(se_hi), 32'd16);
    check("se8_after_done", 32'(se8), 32'd0);
    check("si8_unload_zero", 32'(si_bad), 32'd0);
    check("busy8_unbroken", 32'(busy_bad), 32'd0);
    check("busy8_fall", 32'(s8.busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [7:0] d;
    bit         transp;
    bit         mid;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 8'h3C};
    vecs[1] = '{8'h96, 8'h00, 1'b1, 1'b0, 8'h96};
    vecs[2] = '{8'h5A, 8'hC3, 1'b0, 1'b1, 8'hC3};
    vecs[3] = '{8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF};
    vecs[4] = '{8'hF0, 8'h0F, 1'b1, 1'b1, 8'hF0};

    r = 1'b1;
    s8.start = 1'b0; s8.pattern = '0; d8 = '0; tr8 = 1'b0;
    s2.start = 1'b0; s2.pattern = '0; d2 = '0;
    repeat (3) @(negedge clk);
    check("rst_se8", 32'(se8), 32'd0);
    check("rst_si8", 32'(si8), 32'd0);
    check("rst_busy8", 32'(s8.busy), 32'd0);
    check("rst_done8", 32'(s8.done), 32'd0);
    check("rst_resp8", 32'(s8.response), 32'd0);
    check("rst_se2", 32'(se2), 32'd0);
    check("rst_busy2", 32'(s2.busy), 32'd0);
    check("rst_resp2", 32'(s2.response), 32'd0);
    r = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_se8", 32'(se8), 32'd0);

    for (int k = 0; k < 5; k++) begin
      run8(vecs[k].pat, vecs[k].d, vecs[k].transp, vecs[k].exp,
           1'b0, vecs[k].mid, 1'b0, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
    end

    // Abort mid-shift: outputs clear and no done follows
    @(negedge clk);
    s8.start = 1'b1; s8.pattern = 8'h5A; d8 = 8'h77; tr8 = 1'b0;
    sb8.push_back(8'h77);
    @(negedge clk);
    s8.start = 1'b0;
    repeat (3) @(negedge clk);
    r = 1'b1;
    sb8.delete();
    @(negedge clk);
    r = 1'b0;
    check("abort_se8", 32'(se8), 32'd0);
    check("abort_busy8", 32'(s8.busy), 32'd0);
    check("abort_resp8", 32'(s8.response), 32'd0);
    check("abort_done8", 32'(s8.done), 32'd0);
    repeat (25) @(negedge clk);
    check("abort_idle_busy8", 32'(s8.busy), 32'd0);

    // Back-to-back: start held from the last unload cycle through the done cycle
    run8(8'h3C, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00);
    run8(8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Minimum chain length
    @(negedge clk);
    s2.start = 1'b1; s2.pattern = 2'b10; d2 = 2'b01;
    sb2.push_back(2'b01);
    @(negedge clk);
    s2.start = 1'b0; s2.pattern = 2'b00;
    check("busy2_rise", 32'(s2.busy), 32'd1);
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (s2.done === 1'b1) begin
        lat = j;
        break;
      end
      if (j == 2) begin
        check("se2_capture_low", 32'(se2), 32'd0);
        check("chain_load2", 32'(q2), 32'd2);
      end
    end
    check("latency2", 32'(lat), 32'd5);
    check("busy2_fall", 32'(s2.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("sb8_drained", 32'(sb8.size()), 32'd0);
    check("sb2_drained", 32'(sb2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
